instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 64, maximum words accepted per load session; CW = $clog2(MAX_WORDS+1).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begins a load session; honored only in IDLE.
REQ-006 in_valid / in_ready  in / out  1 / 1  field-set handshake.
REQ-007 in_fmt  in  2  instruction format: 00 R, 01 I, 10 J, 11 illegal.
REQ-008 in_opcode  in  6; in_rs, in_rt, in_rd, in_shamt  in  5 each; in_funct  in  6; in_imm  in  16; in_target  in  26.
REQ-009 in_last  in  1  marks the final field-set of the session; qualified by the handshake.
REQ-010 imem_we  out  1  instruction-memory write request.
REQ-011 imem_addr  out  32  write byte address.
REQ-012 imem_wd  out  32  encoded instruction word.
REQ-013 imem_ack  in  1  memory accepts the write this cycle.
REQ-014 busy  out  1  high in LOAD and DRAIN.
REQ-015 done  out  1  one-cycle pulse at end of session.
REQ-016 err  out  1  sticky illegal-input flag; cleared by start or rst.
REQ-017 word_count  out  CW  words written to memory this session.

Function
REQ-018 FSM states IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE + start -> LOAD; address register <= BASE_ADDR, word_count <= 0, accepted count <= 0, err <= 0.
REQ-020 in_ready = (state==LOAD) && FIFO not full && accepted count < MAX_WORDS.
REQ-021 Accept = in_valid && in_ready; encoded word pushed into a 2-entry FIFO at that edge.
REQ-022 Encoding: R = {in_opcode, rs, rt, rd, shamt, funct}; I = {in_opcode, rs, rt, imm}; J = {in_opcode, target}.
REQ-023 fmt 11, or fmt R with in_opcode != 0: err <= 1; word not pushed or counted; handshake still completes, in_last still honored.
REQ-024 imem_we = FIFO non-empty; imem_wd = FIFO head; imem_addr = address register.
REQ-025 Retire on imem_we && imem_ack: pop FIFO, address += 4 (mod 2^32 wrap), word_count += 1.
REQ-026 imem_we, imem_addr, imem_wd held stable while imem_ack low.
REQ-027 Latency: accepted word on imem_wd no earlier than the cycle after acceptance; one word per cycle sustained with imem_ack high.
REQ-028 Simultaneous push and pop: both occur; occupancy unchanged.
REQ-029 LOAD -> DRAIN when an accepted transfer has in_last=1, or when the accepted count reaches MAX_WORDS.
REQ-030 DRAIN -> DONE when the FIFO is empty, including the cycle its last entry retires.
REQ-031 DONE: done=1 for exactly one cycle, then IDLE; word_count and err hold until next start.
REQ-032 start ignored outside IDLE.

Reset
REQ-033 rst high at an edge: state=IDLE, FIFO emptied, pending words discarded, address=BASE_ADDR, word_count=0.
REQ-034 Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wd=0, busy=0, done=0, err=0, word_count=0.
REQ-035 Reset mid-session aborts without further memory writes; rst dominates start in the same cycle.

Verification
REQ-036 start; I fmt opcode 08 rs 0 rt 8 imm 0005 with last -> one write 0x20080005 at 0x0; done pulse; word_count=1.
REQ-037 R fmt rs 8 rt 9 rd 10 shamt 0 funct 20, then J opcode 02 target 0x0100000 with last -> writes 0x01095020 @0x0, 0x08100000 @0x4.
REQ-038 imem_ack held low 5 cycles during a 3-word stream -> in_ready drops after 2 accepts; outputs stable; all 3 words written in order.
REQ-039 fmt 11 between two valid words -> err=1; only 2 writes at 0x0, 0x4; word_count=2.
REQ-040 MAX_WORDS=4, 6 words offered, no last -> 4 writes, 5th never accepted, done pulse.
REQ-041 BASE_ADDR=32'hFFFF_FFFC, 2 words -> addresses 0xFFFFFFFC, 0x00000000; separately rst mid-DRAIN -> imem_we=0 next cycle, IDLE.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: packs R/I/J field-sets into 32-bit instruction words and
// streams them through a 2-entry FIFO to an instruction-memory write port.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64,
  localparam int         CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_fmt,
  input  logic [5:0]    in_opcode,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wd,
  input  logic          imem_ack,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;

  function automatic logic fmt_legal(input logic [1:0] fmt, input logic [5:0] opcode);
    case (fmt)
      FMT_R:   fmt_legal = (opcode == 6'd0);
      FMT_I:   fmt_legal = 1'b1;
      FMT_J:   fmt_legal = 1'b1;
      default: fmt_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] encode(
    input logic [1:0]  fmt,
    input logic [5:0]  opcode,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    case (fmt)
      FMT_R:   encode = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   encode = {opcode, rs, rt, imm};
      default: encode = {opcode, target};
    endcase
  endfunction

  state_t        state;
  logic [31:0]   fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_cnt;
  logic [31:0]   addr_q;
  logic [CW-1:0] acc_cnt;

  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          legal_p0;
  logic [31:0]   enc_p0;
  logic          push;
  logic          pop;
  logic          hit_max;
  logic          vld_p1;
  logic [31:0]   head_p1;

  // Stage p0: field-set on the input handshake, encoded combinationally.
  always_comb begin
    fifo_full  = (fifo_cnt == 2'd2);
    fifo_empty = (fifo_cnt == 2'd0);
    in_ready   = (state == LOAD) && !fifo_full && (acc_cnt < CW'(MAX_WORDS));
    accept     = in_valid && in_ready;
    legal_p0   = fmt_legal(in_fmt, in_opcode);
    enc_p0     = encode(in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt,
                        in_funct, in_imm, in_target);
    push       = accept && legal_p0;
    hit_max    = push && (acc_cnt == CW'(MAX_WORDS - 1));
    vld_p1     = !fifo_empty;
    head_p1    = fifo_mem[rd_ptr];
    pop        = vld_p1 && imem_ack;
  end

  // Stage p1: FIFO head presented to the memory port until acknowledged.
  always_comb begin
    imem_we   = vld_p1;
    imem_wd   = vld_p1 ? head_p1 : 32'd0;
    imem_addr = addr_q;
    busy      = (state == LOAD) || (state == DRAIN);
    done      = (state == DONE);
  end

  // FIFO storage is data only; occupancy and pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
      addr_q     <= BASE_ADDR;
      word_count <= '0;
      acc_cnt    <= '0;
      err        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        acc_cnt <= acc_cnt + CW'(1);
      end
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        addr_q     <= addr_q + 32'd4;
        word_count <= word_count + CW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (accept && !legal_p0) err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            addr_q     <= BASE_ADDR;
            word_count <= '0;
            acc_cnt    <= '0;
            err        <= 1'b0;
          end
        end
        LOAD: begin
          // An illegal field-set still ends the session if it carries in_last.
          if ((accept && in_last) || hit_max) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty || (fifo_cnt == 2'd1 && pop)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
